shift_add_mult: RTL and testbench
=================================

SHIFT_ADD_MULT -- requirements
Module: shift_add_mult

Interface
REQ-001 Parameter WIDTH, default 12, operand width in bits; product width is 2*WIDTH.
REQ-002 clk  input  1  clock; all state changes on rising edge.
REQ-003 reset  input  1  reset, asynchronous, active-high.
REQ-004 x_parallel  input  WIDTH  multiplicand from upstream serial-to-parallel stage.
REQ-005 fx  input  1  x operand full flag; level, high while x_parallel holds a complete operand.
REQ-006 y_parallel  input  WIDTH  multiplier from second serial-to-parallel stage.
REQ-007 fy  input  1  y operand full flag; level, same semantics as fx.
REQ-008 product  output  2*WIDTH  registered unsigned product x*y.
REQ-009 busy  output  1  high while multiplication in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse; product valid and stable from this cycle.

Function
REQ-011 FSM states: IDLE, RUN, DONE; encoding binary, 2 bits.
REQ-012 arm flag register: arm <= NOT(fx AND fy) on every edge.
REQ-013 Start condition: state IDLE AND fx AND fy AND arm (rising coincidence of both flags).
REQ-014 On the start edge (E0): multiplicand <= x_parallel, multiplier <= y_parallel, accumulator <= 0, count <= 0, state -> RUN.
REQ-015 Each RUN edge: if multiplier LSB = 1, upper accumulator half += multiplicand with carry kept (WIDTH+1 bits); then {carry, accumulator, multiplier} shifts right by one; count += 1.
REQ-016 RUN lasts exactly WIDTH edges (E1..E12 for WIDTH=12); at E_WIDTH, product <= final {accumulator, multiplier}, state -> DONE.
REQ-017 DONE lasts exactly one cycle; done = 1 only in DONE; next edge state -> IDLE unconditionally.
REQ-018 Latency: done high in the cycle after edge E_WIDTH, i.e. WIDTH+1 edges after start edge inclusive of E0.
REQ-019 busy = 1 exactly in RUN; busy and done never high together.
REQ-020 product holds its value in IDLE, RUN and DONE until overwritten at next E_WIDTH.
REQ-021 Operands captured at E0 only; changes to x_parallel, y_parallel, fx, fy during RUN/DONE have no effect.
REQ-022 Start condition arising outside IDLE is dropped, not queued; a new start requires fx AND fy low for at least one cycle, then high, while in IDLE.
REQ-023 fx high with fy low (or vice versa) never starts a multiplication.
REQ-024 Arithmetic unsigned; no overflow possible: max 4095*4095 = 0xFFE001 fits 24 bits.

Reset
REQ-025 reset asserted: state <= IDLE, product <= 0, busy = 0, done = 0, count <= 0, accumulator/multiplicand/multiplier <= 0, arm <= 0.
REQ-026 reset mid-RUN aborts immediately; product reads 0, no done pulse issued for aborted operation.
REQ-027 After reset release, fx AND fy already high does not start (arm = 0); flags must drop and re-rise.

Structure
REQ-028 Shared package mult_pkg holds WIDTH default constant and FSM state typedef/encodings; upstream shift stages and downstream serializer import the same WIDTH.
REQ-029 One sub-module, start_detect: registers arm and outputs the single-cycle start qualifier from fx, fy, state==IDLE.
REQ-030 Datapath (add, shift, counter) and FSM in shift_add_mult itself; no multiplier operator inferred.

Verification
REQ-031 x=3, y=5, fx/fy rise together -> busy 12 cycles, done pulse one cycle later, product=0x00000F.
REQ-032 x=4095, y=4095 -> product=0xFFE001 at done; x=0, y=4095 -> product=0x000000, done still pulses.
REQ-033 fx rises, fy rises 4 cycles later -> start on fy edge; change x_parallel to 0 during RUN -> product unchanged from captured operands.
REQ-034 fx,fy held high through DONE and beyond -> exactly one done pulse; drop both one cycle, re-raise with x=2,y=7 -> second run, product=0x00000E.
REQ-035 reset asserted at RUN cycle 6 of 100*200 -> product=0, busy=0, no done; flags still high after release -> no start until re-armed.
REQ-036 fx high, fy held low 50 cycles -> busy and done remain 0, product unchanged.

Source files
------------

// File: rtl/mult_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mult_pkg
// Brief    : Shared constants and FSM state encoding for the serial
//            shift-add multiplier and its neighbouring shift stages.
// Revision : 1.0  initial release
// ============================================================================
package mult_pkg;

  // Operand width shared by the serial-to-parallel stages, the multiplier
  // and the downstream serializer.
  localparam int WIDTH_DEFAULT = 12;

  // Multiplier control states, binary encoded in two bits.
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_DONE = 2'b10
  } state_t;

endpackage : mult_pkg
`default_nettype wire

// File: rtl/start_detect.sv
`default_nettype none
// ============================================================================
// Module   : start_detect
// Brief    : Qualifies a multiplication start on the rising coincidence of
//            both operand-full flags while the multiplier is idle.
// Revision : 1.0  initial release
// ============================================================================
module start_detect
  import mult_pkg::*;
(
  input  logic   clk,
  input  logic   reset,
  input  logic   fx,
  input  logic   fy,
  input  state_t state,
  output logic   start
);

  // arm is high only if the flags were not both set on the previous edge,
  // so flags held high (through a run, or across reset) cannot restart.
  logic arm;

  // Arm register: remembers whether the flag pair was broken last cycle.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      arm <= 1'b0;
    end else begin
      arm <= ~(fx & fy);
    end
  end

  assign start = (state == ST_IDLE) & fx & fy & arm;

endmodule : start_detect
`default_nettype wire

// File: rtl/shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module   : shift_add_mult
// Brief    : Unsigned sequential shift-and-add multiplier. Captures both
//            operands on a start edge, iterates WIDTH add/shift steps and
//            registers the 2*WIDTH-bit product with a one-cycle done pulse.
// Revision : 1.0  initial release
// ============================================================================
module shift_add_mult
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEFAULT
)
(
  input  logic               clk,
  input  logic               reset,
  input  logic [WIDTH-1:0]   x_parallel,
  input  logic               fx,
  input  logic [WIDTH-1:0]   y_parallel,
  input  logic               fy,
  output logic [2*WIDTH-1:0] product,
  output logic               busy,
  output logic               done
);

  localparam int            CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(WIDTH - 1);

  state_t           state;
  state_t           state_next;
  logic             start;
  logic [WIDTH-1:0] multiplicand;
  logic [WIDTH-1:0] multiplier;
  logic [WIDTH-1:0] accumulator;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   partial_sum;
  logic             last_step;

  start_detect u_start_detect (
    .clk   (clk),
    .reset (reset),
    .fx    (fx),
    .fy    (fy),
    .state (state),
    .start (start)
  );

  // Upper half plus (optionally) the multiplicand, carry kept in bit WIDTH.
  assign partial_sum = {1'b0, accumulator}
                     + (multiplier[0] ? {1'b0, multiplicand} : '0);
  assign last_step   = (count == LAST_COUNT);

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= ST_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state and status outputs; DONE always falls back to IDLE.
  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) state_next = ST_RUN;
      end
      ST_RUN: begin
        busy = 1'b1;
        if (last_step) state_next = ST_DONE;
      end
      ST_DONE: begin
        done       = 1'b1;
        state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Datapath: operand capture on start, one add/shift step per RUN edge,
  // product registered on the final step and held otherwise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      multiplicand <= '0;
      multiplier   <= '0;
      accumulator  <= '0;
      count        <= '0;
      product      <= '0;
    end else if (start) begin
      multiplicand <= x_parallel;
      multiplier   <= y_parallel;
      accumulator  <= '0;
      count        <= '0;
    end else if (state == ST_RUN) begin
      // {carry, accumulator, multiplier} shifted right by one.
      accumulator <= partial_sum[WIDTH:1];
      multiplier  <= {partial_sum[0], multiplier[WIDTH-1:1]};
      count       <= count + CW'(1);
      if (last_step) begin
        product <= {partial_sum, multiplier[WIDTH-1:1]};
      end
    end
  end

endmodule : shift_add_mult
`default_nettype wire

// File: tb/tb_shift_add_mult.sv
`default_nettype none
// ============================================================================
// Module   : tb_shift_add_mult
// Brief    : Self-checking bench for shift_add_mult: directed operand table
//            plus hand-written flag/reset sequences.
// Revision : 1.0  initial release
// ============================================================================
module tb_shift_add_mult;

  localparam int W = 12;

  logic           clk = 1'b0;
  logic           reset;
  logic [W-1:0]   x_parallel;
  logic           fx;
  logic [W-1:0]   y_parallel;
  logic           fy;
  logic [2*W-1:0] product;
  logic           busy;
  logic           done;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [W-1:0]   x;
    logic [W-1:0]   y;
    logic [2*W-1:0] p;
  } vec_t;

  shift_add_mult #(.WIDTH(W)) dut (
    .clk        (clk),
    .reset      (reset),
    .x_parallel (x_parallel),
    .fx         (fx),
    .y_parallel (y_parallel),
    .fy         (fy),
    .product    (product),
    .busy       (busy),
    .done       (done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Count negedges until done (bounded); reports busy cycles, latency and overlap.
  task automatic wait_done(output int busy_cyc, output int lat, output bit seen,
                           output int overlap);
    busy_cyc = 0; lat = 0; seen = 1'b0; overlap = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      lat++;
      if (busy && done) overlap++;
      if (busy) busy_cyc++;
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
  endtask

  // Break the flags for one cycle, present operands, raise both flags, check the run.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic [2*W-1:0] exp);
    int bc, lat, ov;
    bit seen;
    @(negedge clk);
    fx = 1'b0; fy = 1'b0;
    @(negedge clk);
    x_parallel = x; y_parallel = y;
    fx = 1'b1; fy = 1'b1;
    wait_done(bc, lat, seen, ov);
    chk({name, " done_seen"}, 64'(seen), 64'd1);
    chk({name, " product"}, 64'(product), 64'(exp));
    chk({name, " busy_cycles"}, 64'(bc), 64'(W));
    chk({name, " latency"}, 64'(lat), 64'(W + 1));
    chk({name, " busy_done_overlap"}, 64'(ov), 64'd0);
    @(negedge clk);
    chk({name, " done_one_cycle"}, 64'(done), 64'd0);
    chk({name, " product_held"}, 64'(product), 64'(exp));
  endtask

  // Watch n cycles for any busy/done activity.
  task automatic quiet(input string name, input int n, input logic [2*W-1:0] exp_p);
    int act = 0;
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      if (busy || done) act++;
    end
    chk({name, " no_activity"}, 64'(act), 64'd0);
    chk({name, " product_unchanged"}, 64'(product), 64'(exp_p));
  endtask

  vec_t vecs[8];

  initial begin
    int bc, lat, ov;
    bit seen;

    vecs[0] = '{x: 12'd3,    y: 12'd5,    p: 24'h00000F};
    vecs[1] = '{x: 12'd4095, y: 12'd4095, p: 24'hFFE001};
    vecs[2] = '{x: 12'd0,    y: 12'd4095, p: 24'h000000};
    vecs[3] = '{x: 12'd1,    y: 12'd1,    p: 24'h000001};
    vecs[4] = '{x: 12'd4095, y: 12'd1,    p: 24'h000FFF};
    vecs[5] = '{x: 12'hABC,  y: 12'h123,  p: 24'h0C33B4};
    vecs[6] = '{x: 12'h800,  y: 12'd2,    p: 24'h001000};
    vecs[7] = '{x: 12'd1,    y: 12'h800,  p: 24'h000800};

    reset = 1'b1; fx = 1'b0; fy = 1'b0; x_parallel = '0; y_parallel = '0;
    repeat (2) @(negedge clk);
    chk("reset product", 64'(product), 64'd0);
    chk("reset busy", 64'(busy), 64'd0);
    chk("reset done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i].x, vecs[i].y, vecs[i].p);
    end

    // Staggered flags: start on fy's edge; operand changes during RUN ignored.
    @(negedge clk);
    fx = 1'b0; fy = 1'b0;
    @(negedge clk);
    x_parallel = 12'd9; y_parallel = 12'd6; fx = 1'b1;
    quiet("stagger_fx_only", 4, 24'h000800);
    fy = 1'b1;
    @(negedge clk);
    chk("stagger start_on_fy", 64'(busy), 64'd1);
    x_parallel = '0; y_parallel = '0;
    wait_done(bc, lat, seen, ov);
    chk("stagger done_seen", 64'(seen), 64'd1);
    chk("stagger product", 64'(product), 64'h36);
    chk("stagger busy_cycles", 64'(bc), 64'(W - 1));

    // Flags still high through DONE and beyond: no second run.
    quiet("held_flags", 20, 24'h000036);
    run_op("rearm", 12'd2, 12'd7, 24'h00000E);

    // Reset in the middle of a run aborts it and clears the product.
    @(negedge clk);
    fx = 1'b0; fy = 1'b0;
    @(negedge clk);
    x_parallel = 12'd100; y_parallel = 12'd200; fx = 1'b1; fy = 1'b1;
    bc = 0;
    for (int i = 0; i < 40 && bc < 6; i++) begin
      @(negedge clk);
      if (busy) bc++;
    end
    chk("abort reached_run6", 64'(bc), 64'd6);
    reset = 1'b1;
    #1;
    chk("abort product", 64'(product), 64'd0);
    chk("abort busy", 64'(busy), 64'd0);
    chk("abort done", 64'(done), 64'd0);
    @(negedge clk);
    reset = 1'b0;
    quiet("post_reset_flags_high", 20, 24'h000000);
    run_op("after_abort", 12'd100, 12'd200, 24'h004E20);

    // One flag alone never starts.
    @(negedge clk);
    fx = 1'b1; fy = 1'b0; x_parallel = 12'd5; y_parallel = 12'd5;
    quiet("fx_only", 50, 24'h004E20);
    fx = 1'b0; fy = 1'b1;
    quiet("fy_only", 20, 24'h004E20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule : tb_shift_add_mult
`default_nettype wire
